mux_nto1_seq: RTL and testbench

Parametrised, registered N:1 word multiplexer with a request/valid/ready handshake. It has two modes:
- Direct mode: selects one input word.
- Scan mode: streams every input word in index order, one word per accepted handshake.

It sits between banks of status/register words and a single-word consumer, for example debug readout or a flag serialiser. It generalises the combinational 16:1 bit mux to WIDTH-bit words, NUM_IN inputs and sequenced readout.

---
 rtl/mux_nto1_seq.sv | 137 +++++++++++++
 tb/tb_mux_nto1_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_seq.sv
// rtl/mux_nto1_seq.sv - registered N:1 word mux with direct and scan readout over a valid/ready handshake
module mux_nto1_seq #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 16,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    req,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Extended by one bit so the range check stays meaningful when NUM_IN is a power of 2.
    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_idx_q, out_idx_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               handshake;
    logic               sel_ok;
    logic [SEL_W-1:0]   idx_next;

    // Word lookup guarded against indices past NUM_IN; those read as zero.
    function automatic logic [WIDTH-1:0] pick(input logic [NUM_IN*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0]        idx);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (idx == SEL_W'(i)) begin
                w = d[i*WIDTH +: WIDTH];
            end
        end
        return w;
    endfunction

    assign handshake = out_valid_q & out_ready;
    assign sel_ok    = ({1'b0, sel} < NUM_IN_EXT);
    assign idx_next  = out_idx_q + SEL_W'(1);

    // Next-state and output-register computation; everything holds unless a request or handshake moves it.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    out_valid_d = 1'b1;
                    if (mode) begin
                        out_idx_d  = '0;
                        out_data_d = pick(data_in, '0);
                        err_d      = 1'b0;
                        state_d    = SCAN;
                    end else begin
                        out_idx_d  = sel;
                        out_data_d = sel_ok ? pick(data_in, sel) : '0;
                        err_d      = ~sel_ok;
                        state_d    = DIRECT;
                    end
                end
            end
            DIRECT: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            SCAN: begin
                if (handshake) begin
                    if (out_idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        out_idx_d  = idx_next;
                        out_data_d = pick(data_in, idx_next);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight word without a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_nto1_seq.sv
// tb/tb_mux_nto1_seq.sv - directed self-checking bench for mux_nto1_seq (NUM_IN=16 and NUM_IN=10)
module tb_mux_nto1_seq;

    logic clk;
    logic rst_n;

    // NUM_IN=16 instance
    logic [16*8-1:0] d16;
    logic            mode16, req16, rdy16;
    logic [3:0]      sel16;
    logic [7:0]      data16;
    logic [3:0]      idx16;
    logic            valid16, err16, busy16, done16;

    // NUM_IN=10 instance
    logic [10*8-1:0] d10;
    logic            mode10, req10, rdy10;
    logic [3:0]      sel10;
    logic [7:0]      data10;
    logic [3:0]      idx10;
    logic            valid10, err10, busy10, done10;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mux_nto1_seq #(.WIDTH(8), .NUM_IN(16)) dut16 (
        .clk(clk), .reset_n(rst_n), .data_in(d16), .mode(mode16), .sel(sel16), .req(req16),
        .out_data(data16), .out_idx(idx16), .out_valid(valid16), .out_ready(rdy16),
        .err(err16), .busy(busy16), .done(done16)
    );

    mux_nto1_seq #(.WIDTH(8), .NUM_IN(10)) dut10 (
        .clk(clk), .reset_n(rst_n), .data_in(d10), .mode(mode10), .sel(sel10), .req(req10),
        .out_data(data10), .out_idx(idx10), .out_valid(valid10), .out_ready(rdy10),
        .err(err10), .busy(busy10), .done(done10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic v, input logic [7:0] d,
                           input logic [3:0] i, input logic dn, input logic b);
        check({tag, " valid"}, {31'd0, valid16}, {31'd0, v});
        check({tag, " data"},  {24'd0, data16},  {24'd0, d});
        check({tag, " idx"},   {28'd0, idx16},   {28'd0, i});
        check({tag, " done"},  {31'd0, done16},  {31'd0, dn});
        check({tag, " busy"},  {31'd0, busy16},  {31'd0, b});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) d16[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 10; i++) d10[i*8 +: 8] = 8'h10 + 8'(i);
        mode16 = 0; req16 = 0; rdy16 = 0; sel16 = 0;
        mode10 = 0; req10 = 0; rdy10 = 0; sel10 = 0;
        rst_n  = 0;
        tick();
        tick();
        check16("reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        check("reset err", {31'd0, err16}, 32'd0);
        rst_n = 1;
        tick();

        // Direct sel=12 with backpressure; word 12 changes during the hold
        req16 = 1; mode16 = 0; sel16 = 4'd12; rdy16 = 0;
        tick();
        req16 = 0; sel16 = 4'd3; mode16 = 1;
        check16("dir first", 1'b1, 8'h1C, 4'd12, 1'b0, 1'b1);
        check("dir err", {31'd0, err16}, 32'd0);
        d16[12*8 +: 8] = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            check16("dir hold", 1'b1, 8'h1C, 4'd12, 1'b0, 1'b1);
        end
        rdy16 = 1;
        tick();
        rdy16 = 0;
        check16("dir done", 1'b0, 8'h1C, 4'd12, 1'b1, 1'b0);
        tick();
        check("dir done pulse", {31'd0, done16}, 32'd0);
        d16[12*8 +: 8] = 8'h1C;

        // Full scan with continuous ready
        req16 = 1; mode16 = 1; rdy16 = 1;
        tick();
        req16 = 0;
        for (int i = 0; i < 16; i++) begin
            check16("scan", 1'b1, 8'h10 + 8'(i), 4'(i), 1'b0, 1'b1);
            tick();
        end
        check("scan end valid", {31'd0, valid16}, 32'd0);
        check("scan end done", {31'd0, done16}, 32'd1);
        check("scan end busy", {31'd0, busy16}, 32'd0);
        tick();

        // Full scan with ready toggling: each word held until accepted
        rdy16 = 0; req16 = 1; mode16 = 1;
        tick();
        req16 = 0;
        for (int i = 0; i < 16; i++) begin
            check16("tscan", 1'b1, 8'h10 + 8'(i), 4'(i), 1'b0, 1'b1);
            tick();
            check16("tscan hold", 1'b1, 8'h10 + 8'(i), 4'(i), 1'b0, 1'b1);
            rdy16 = 1;
            tick();
            rdy16 = 0;
        end
        check("tscan end valid", {31'd0, valid16}, 32'd0);
        check("tscan end done", {31'd0, done16}, 32'd1);
        tick();

        // req during scan ignored, then req in the done cycle accepted
        req16 = 1; mode16 = 1; rdy16 = 1;
        tick();
        req16 = 0;
        for (int i = 0; i < 16; i++) begin
            check16("rscan", 1'b1, 8'h10 + 8'(i), 4'(i), 1'b0, 1'b1);
            if (i == 3) begin
                req16 = 1; mode16 = 0; sel16 = 4'd7;
            end
            tick();
            req16 = 0;
        end
        check16("rscan done", 1'b0, 8'h1F, 4'd15, 1'b1, 1'b0);
        req16 = 1; mode16 = 0; sel16 = 4'd2;
        tick();
        req16 = 0;
        check16("b2b", 1'b1, 8'h12, 4'd2, 1'b0, 1'b1);
        tick();
        check16("b2b done", 1'b0, 8'h12, 4'd2, 1'b1, 1'b0);
        tick();

        // Asynchronous reset mid-scan at idx 5
        req16 = 1; mode16 = 1; rdy16 = 1;
        tick();
        req16 = 0;
        for (int i = 0; i < 5; i++) tick();
        rdy16 = 0;
        check("pre-reset idx", {28'd0, idx16}, 32'd5);
        rst_n = 0;
        #1;
        check16("async reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1;
        tick();
        check16("post reset", 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
        req16 = 1; mode16 = 0; sel16 = 4'd9;
        tick();
        req16 = 0;
        check16("post reset req", 1'b1, 8'h19, 4'd9, 1'b0, 1'b1);

        // NUM_IN=10: out-of-range direct select
        req10 = 1; mode10 = 0; sel10 = 4'd11; rdy10 = 1;
        tick();
        req10 = 0;
        check("n10 err", {31'd0, err10}, 32'd1);
        check("n10 err data", {24'd0, data10}, 32'h00);
        check("n10 err valid", {31'd0, valid10}, 32'd1);
        check("n10 err idx", {28'd0, idx10}, 32'd11);
        tick();
        check("n10 err done", {31'd0, done10}, 32'd1);
        tick();

        // NUM_IN=10: scan stops after index 9
        req10 = 1; mode10 = 1;
        tick();
        req10 = 0;
        for (int i = 0; i < 10; i++) begin
            check("n10 scan valid", {31'd0, valid10}, 32'd1);
            check("n10 scan idx", {28'd0, idx10}, 32'(i));
            check("n10 scan data", {24'd0, data10}, 32'h10 + 32'(i));
            check("n10 scan err", {31'd0, err10}, 32'd0);
            tick();
        end
        check("n10 end valid", {31'd0, valid10}, 32'd0);
        check("n10 end done", {31'd0, done10}, 32'd1);
        check("n10 end busy", {31'd0, busy10}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
